score_display: RTL and testbench

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display_pkg.sv | 38 +++
 rtl/score_display_seg7_decode.sv | 32 +++
 rtl/score_display.sv | 131 +++++++++++++
 tb/tb_score_display.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared definitions for the score display: FSM states, the segment patterns,
// the conversion iteration count and the double-dabble step.
package score_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  localparam int CONVERT_CYCLES = 16;
  localparam int ITER_W         = $clog2(CONVERT_CYCLES);

  // Active-low segments ordered {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One double-dabble iteration on {bcd[19:0], shift[15:0]}: correct every
  // BCD nibble >= 5 by +3, then shift the whole vector left by one.
  function automatic logic [35:0] dabble_step(input logic [35:0] acc);
    logic [19:0] bcd;
    bcd = acc[35:16];
    for (int n = 0; n < 5; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) bcd[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
    return {bcd, acc[15:0]} << 1;
  endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// Nibble to 7-segment decoder (active-low).
//   digit_i : BCD digit 0..9 (other codes show blank)
//   blank_i : force all segments off
//   seg_o   : segments {a,b,c,d,e,f,g}, active low
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed 7-segment score display.
// A 16-bit binary score is converted to BCD by a sequential double-dabble
// engine whenever it changes; the result is committed to the digit registers
// in one step so the scan never shows a half-converted value.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   score  : binary score input
//   anode  : active-low digit enables, anode[0] = ones digit
//   ssdOut : active-low segments {a..g}
//   busy   : conversion in progress (CONVERT or COMMIT)
//
// state      | meaning
// ST_IDLE    | waiting for score to differ from last_score
// ST_CONVERT | 16 double-dabble iterations
// ST_COMMIT  | load digit registers from the BCD result
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] score,
  output logic [3:0]  anode,
  output logic [6:0]  ssdOut,
  output logic        busy
);

  state_e                  state_q;
  logic [15:0]             last_score_q;
  logic [15:0]             shift_q;
  logic [19:0]             bcd_q;
  logic [ITER_W-1:0]       iter_q;
  logic                    busy_q;
  logic [3:0][3:0]         digits_q;
  logic [3:0][3:0]         digits_d;
  logic [35:0]             dabble_d;

  logic [REFRESH_BITS-1:0] scan_q;
  logic [3:0]              anode_q;
  logic [6:0]              ssd_q;
  logic [1:0]              sel;
  logic [3:0]              blank_vec;
  logic [3:0]              cur_digit;
  logic [6:0]              seg_d;

  assign dabble_d = dabble_step({bcd_q, shift_q});

  // A nonzero ten-thousands nibble saturates the display to 9999.
  always_comb begin
    digits_d = bcd_q[15:0];
    if (bcd_q[19:16] != 4'd0) digits_d = {4'd9, 4'd9, 4'd9, 4'd9};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_score_q <= '0;
      shift_q      <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      busy_q       <= 1'b0;
      digits_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (score != last_score_q) begin
            last_score_q <= score;
            shift_q      <= score;
            bcd_q        <= '0;
            iter_q       <= ITER_W'(CONVERT_CYCLES - 1);
            busy_q       <= 1'b1;
            state_q      <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          {bcd_q, shift_q} <= dabble_d;
          if (iter_q == '0) begin
            state_q <= ST_COMMIT;
          end else begin
            iter_q <= iter_q - 1'b1;
          end
        end
        ST_COMMIT: begin
          digits_q <= digits_d;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Leading-zero blanking: a digit is blank only while it and every higher
  // digit are zero; the ones digit always shows.
  always_comb begin
    blank_vec    = '0;
    blank_vec[3] = (digits_q[3] == 4'd0);
    blank_vec[2] = blank_vec[3] && (digits_q[2] == 4'd0);
    blank_vec[1] = blank_vec[2] && (digits_q[1] == 4'd0);
  end

  assign sel       = scan_q[REFRESH_BITS-1 -: 2];
  assign cur_digit = digits_q[sel];

  seg7_decode u_seg7_decode (
    .digit_i (cur_digit),
    .blank_i (blank_vec[sel]),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q  <= '0;
      anode_q <= 4'b1111;
      ssd_q   <= SEG_BLANK;
    end else begin
      scan_q  <= scan_q + REFRESH_BITS'(1);
      anode_q <= ~(4'b0001 << sel);
      ssd_q   <= seg_d;
    end
  end

  assign anode  = anode_q;
  assign ssdOut = ssd_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  logic        clk;
  logic        reset;
  logic [15:0] score;
  logic [3:0]  anode;
  logic [6:0]  ssdOut;
  logic        busy;

  int errors = 0;
  int checks = 0;
  string phase = "init";

  // Reference model state
  int disp_val;
  int last_m;
  int pending_m;
  int left_m;
  int scan_m;
  logic [3:0] exp_anode;
  logic [6:0] exp_ssd;
  logic       exp_busy;

  logic [6:0] seg_tab [10];
  int         pow10 [4];

  score_display #(.REFRESH_BITS(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .score  (score),
    .anode  (anode),
    .ssdOut (ssdOut),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    disp_val  = 0;
    last_m    = 0;
    pending_m = 0;
    left_m    = 0;
    scan_m    = 0;
  endtask

  task automatic check_outputs();
    checks++;
    assert (anode === exp_anode) else begin
      errors++;
      $error("FAIL %s anode observed=%b expected=%b", phase, anode, exp_anode);
    end
    checks++;
    assert (ssdOut === exp_ssd) else begin
      errors++;
      $error("FAIL %s ssdOut observed=%b expected=%b", phase, ssdOut, exp_ssd);
    end
    checks++;
    assert (busy === exp_busy) else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", phase, busy, exp_busy);
    end
  endtask

  task automatic check_reset_values();
    exp_anode = 4'b1111;
    exp_ssd   = 7'b1111111;
    exp_busy  = 1'b0;
    check_outputs();
  endtask

  // One clock: predict what the registered outputs show after the edge,
  // advance the model, then compare.
  task automatic tick();
    int sel;
    int dg;
    bit blank;
    sel = (scan_m / 4) % 4;
    dg = (disp_val / pow10[sel]) % 10;
    blank = (sel > 0) && (disp_val < pow10[sel]);
    exp_anode = 4'b1111 & ~(4'b0001 << sel);
    exp_ssd = blank ? 7'b1111111 : seg_tab[dg];
    if (left_m > 0) begin
      left_m--;
      if (left_m == 0) disp_val = (pending_m > 9999) ? 9999 : pending_m;
    end else if (int'(score) != last_m) begin
      last_m = int'(score);
      pending_m = int'(score);
      left_m = 17;
    end
    scan_m = (scan_m + 1) % 16;
    exp_busy = (left_m > 0);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
    seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
    seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;
    pow10[0] = 1; pow10[1] = 10; pow10[2] = 100; pow10[3] = 1000;

    phase = "reset";
    reset = 1'b1;
    score = 16'd0;
    #2;
    check_reset_values();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    phase = "idle_zero";
    run(20);

    phase = "score_1234";
    score = 16'd1234;
    run(40);

    phase = "score_65535";
    score = 16'd65535;
    run(40);

    phase = "score_7_then_42";
    score = 16'd7;
    run(5);
    score = 16'd42;
    run(60);

    phase = "score_1000";
    score = 16'd1000;
    run(40);

    // Reset landing in the middle of a conversion: capture edge + 8 CONVERT edges.
    phase = "mid_convert_reset";
    score = 16'd4321;
    run(9);
    reset = 1'b1;
    #1;
    check_reset_values();
    score = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    phase = "after_reset_zero";
    run(20);

    phase = "random";
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       score = 16'($urandom_range(0, 9));
        1:       score = 16'($urandom_range(10, 999));
        2:       score = 16'($urandom_range(1000, 9999));
        default: score = 16'($urandom_range(10000, 65535));
      endcase
      run($urandom_range(1, 30));
    end
    phase = "random_settle";
    run(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
